decode_stage: RTL
=================

Name: decode_stage

Overview:
- Second pipeline stage (B→C) of the RV32I core. Sits directly downstream of fetch and consumes its InstrB, PCB and PCPlus4B.
- Decodes the instruction into control signals and generates the sign-extended immediate.
- Holds the 32x32 integer register file, with the write-back port driven from stage E.
- Registers everything into the C-side (execute) pipeline register. Supports branch/jump flush by inserting bubbles.

Parameters:
- DATA_WIDTH, 32, width of datapath, PC and registers.
- NUM_REGS, 32, register file depth (x0 hardwired to zero).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- InstrB  in  32  instruction from fetch.
- PCB  in  DATA_WIDTH  PC of InstrB.
- PCPlus4B  in  DATA_WIDTH  PCB+4.
- FlushC  in  1  branch/jump taken in execute (same signal as PCSrcA).
- RegWriteE  in  1  write-back enable.
- RdE  in  5  write-back destination.
- ResultE  in  DATA_WIDTH  write-back data.
- RD1C, RD2C  out  DATA_WIDTH  rs1/rs2 operand values.
- ImmExtC  out  DATA_WIDTH  sign-extended immediate.
- PCC, PCPlus4C  out  DATA_WIDTH  forwarded PC values.
- Rs1C, Rs2C, RdC  out  5  register indices (for hazard unit).
- Funct3C  out  3  funct3 (branch condition / load-store size).
- RegWriteC, MemWriteC, JumpC, BranchC, ALUSrcC, ALUSrcAC  out  1 each  control.
- ResultSrcC  out  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlC  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASSB.
- IllegalC  out  1  unrecognised opcode.

Behaviour:
- Reset: rst_n sampled low at a rising edge → all C outputs 0, flush_pending 0, all registers x1..x31 = 0. No asynchronous path.
- Latency: one cycle. Values presented on B inputs at edge N appear on C outputs after edge N.
- Register file:
  - Write on rising edge when RegWriteE=1 and RdE≠0.
  - Writes to x0 are ignored; x0 always reads 0.
  - Write-through bypass: if RegWriteE=1, RdE≠0 and RdE equals rs1 or rs2, the read returns ResultE in the same cycle.
- Opcode decode (ALUSrcAC=1 only for AUIPC, selecting PC as operand A):
  - R-type 0110011: RegWrite=1, ALUSrc=0, ALUControl from funct3/funct7[5]; SUB/SRA use funct7[5]=1.
  - I-ALU 0010011: RegWrite=1, ALUSrc=1, I-imm. SRAI uses funct7[5].
  - LOAD 0000011: RegWrite=1, ALUSrc=1, ResultSrc=01, ADD, I-imm.
  - STORE 0100011: MemWrite=1, ALUSrc=1, ADD, S-imm.
  - BRANCH 1100011: Branch=1, SUB, B-imm (bit0=0).
  - JAL 1101111: Jump=1, RegWrite=1, ResultSrc=10, J-imm.
  - JALR 1100111: Jump=1, RegWrite=1, ResultSrc=10, ALUSrc=1, ADD, I-imm.
  - LUI 0110111: RegWrite=1, ALUSrc=1, PASSB, U-imm.
  - AUIPC 0010111: RegWrite=1, ALUSrc=1, ALUSrcA=1, ADD, U-imm.
  - Any other opcode: all control bits 0, IllegalC=1.
  - Instruction 0x00000000 decodes as illegal and is therefore a bubble.
- Immediates: sign bit is always InstrB[31]. U-imm = {InstrB[31:12], 12'b0}.
- Flush:
  - FlushC=1 at an edge → C control bits (RegWrite, MemWrite, Jump, Branch, IllegalC) cleared at that edge, and flush_pending set.
  - flush_pending=1 at the next edge → that instruction (wrong-path, already registered in fetch) is also bubbled; flush_pending then clears.
  - FlushC while flush_pending=1 → bubble this edge, and flush_pending stays 1.
  - Datapath fields (RD1C, ImmExtC, PCC, …) may update during a bubble; only control is cleared.
- Reset has priority over flush and write-back. Reset mid-flush clears flush_pending.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with InstrB=0x00500093 → all C outputs 0. Then release → after 1 edge RegWriteC=1, ALUSrcC=1, ImmExtC=5, RdC=1.
- Register file with bypass: RegWriteE=1, RdE=3, ResultE=0xDEADBEEF at the same cycle as InstrB=0x003100B3 (add x1,x2,x3) → RD2C=0xDEADBEEF. A write to RdE=0 with 0x1234 → a later read of x0 gives 0.
- Immediates:
  - 0xFE000EE3 (beq x0,x0,-4) → BranchC=1, ImmExtC=0xFFFFFFFC.
  - 0x800000EF (jal x1) → JumpC=1, ResultSrcC=10, ImmExtC=0xFFF00000.
  - 0x123450B7 (lui) → ImmExtC=0x12345000, ALUControlC=10.
- ALU decode: 0x40315033 (sra) → ALUControlC=9. 0x0020A023 (sw) → MemWriteC=1, RegWriteC=0, ImmExtC=0.
- Flush: pulse FlushC for 1 cycle during a stream of addi instructions → exactly 2 consecutive C bubbles (RegWriteC=0), then normal flow. FlushC on two consecutive cycles → 3 bubbles.
- Illegal: InstrB=0xFFFFFFFF → IllegalC=1, all other control 0. InstrB=0x00000000 → bubble.

Source files
------------

// File: rtl/decode_stage_if.sv
// Bundle between fetch (B side), write-back (E side) and the decode stage's execute-facing register (C side).
// The slave modport is the decode stage's view; the master is whatever drives and consumes it.
interface decode_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           InstrB;
    logic [DATA_WIDTH-1:0] PCB;
    logic [DATA_WIDTH-1:0] PCPlus4B;
    logic                  FlushC;
    logic                  RegWriteE;
    logic [4:0]            RdE;
    logic [DATA_WIDTH-1:0] ResultE;

    logic [DATA_WIDTH-1:0] RD1C;
    logic [DATA_WIDTH-1:0] RD2C;
    logic [DATA_WIDTH-1:0] ImmExtC;
    logic [DATA_WIDTH-1:0] PCC;
    logic [DATA_WIDTH-1:0] PCPlus4C;
    logic [4:0]            Rs1C;
    logic [4:0]            Rs2C;
    logic [4:0]            RdC;
    logic [2:0]            Funct3C;
    logic                  RegWriteC;
    logic                  MemWriteC;
    logic                  JumpC;
    logic                  BranchC;
    logic                  ALUSrcC;
    logic                  ALUSrcAC;
    logic [1:0]            ResultSrcC;
    logic [3:0]            ALUControlC;
    logic                  IllegalC;

    modport slave (
        input  InstrB, PCB, PCPlus4B, FlushC, RegWriteE, RdE, ResultE,
        output RD1C, RD2C, ImmExtC, PCC, PCPlus4C, Rs1C, Rs2C, RdC, Funct3C,
               RegWriteC, MemWriteC, JumpC, BranchC, ALUSrcC, ALUSrcAC,
               ResultSrcC, ALUControlC, IllegalC
    );

    modport master (
        output InstrB, PCB, PCPlus4B, FlushC, RegWriteE, RdE, ResultE,
        input  RD1C, RD2C, ImmExtC, PCC, PCPlus4C, Rs1C, Rs2C, RdC, Funct3C,
               RegWriteC, MemWriteC, JumpC, BranchC, ALUSrcC, ALUSrcAC,
               ResultSrcC, ALUControlC, IllegalC
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, immediate generation, register file with write-through,
// and the C-side pipeline register with two-deep flush bubbling.
//
// state          | meaning
// FLUSH_IDLE     | normal flow; decoded control passes into the C register
// FLUSH_PENDING  | a flush hit last edge; the wrong-path instruction now in B is bubbled
module decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decode_stage_if.slave        bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef enum logic {
        FLUSH_IDLE,
        FLUSH_PENDING
    } flush_state_t;

    flush_state_t state, state_next;
    logic         bubble;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [4:0]  rs1, rs2, rd;

    logic                  dec_reg_write;
    logic                  dec_mem_write;
    logic                  dec_jump;
    logic                  dec_branch;
    logic                  dec_alu_src;
    logic                  dec_alu_src_a;
    logic [1:0]            dec_result_src;
    logic [3:0]            dec_alu_ctrl;
    logic                  dec_illegal;
    logic [DATA_WIDTH-1:0] imm_ext;

    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] rd1, rd2;

    assign instr     = bus.InstrB;
    assign opcode    = instr[6:0];
    assign rd        = instr[11:7];
    assign funct3    = instr[14:12];
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign funct7_b5 = instr[30];

    // funct3 -> ALU op; SUB only exists for R-type, SRA/SRAI for both
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic f7b5,
                                                  input logic allow_sub);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = (allow_sub && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_write  = 1'b0;
        dec_jump       = 1'b0;
        dec_branch     = 1'b0;
        dec_alu_src    = 1'b0;
        dec_alu_src_a  = 1'b0;
        dec_result_src = 2'b00;
        dec_alu_ctrl   = ALU_ADD;
        dec_illegal    = 1'b0;
        imm_ext        = '0;
        case (opcode)
            OP_R: begin
                dec_reg_write = 1'b1;
                dec_alu_ctrl  = alu_from_funct(funct3, funct7_b5, 1'b1);
            end
            OP_I_ALU: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_ctrl  = alu_from_funct(funct3, funct7_b5, 1'b0);
                imm_ext       = {{20{instr[31]}}, instr[31:20]};
            end
            OP_LOAD: begin
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_result_src = 2'b01;
                imm_ext        = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                imm_ext       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                dec_branch   = 1'b1;
                dec_alu_ctrl = ALU_SUB;
                imm_ext      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            end
            OP_JAL: begin
                dec_jump       = 1'b1;
                dec_reg_write  = 1'b1;
                dec_result_src = 2'b10;
                imm_ext        = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                  instr[30:21], 1'b0};
            end
            OP_JALR: begin
                dec_jump       = 1'b1;
                dec_reg_write  = 1'b1;
                dec_result_src = 2'b10;
                dec_alu_src    = 1'b1;
                imm_ext        = {{20{instr[31]}}, instr[31:20]};
            end
            OP_LUI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_ctrl  = ALU_PASSB;
                imm_ext       = {instr[31:12], 12'b0};
            end
            OP_AUIPC: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_src_a = 1'b1;
                imm_ext       = {instr[31:12], 12'b0};
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Write-through: a same-cycle write to a source register is seen by this read
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0)
            rd1 = (bus.RegWriteE && bus.RdE == rs1) ? bus.ResultE : regs[rs1];
        if (rs2 != 5'd0)
            rd2 = (bus.RegWriteE && bus.RdE == rs2) ? bus.ResultE : regs[rs2];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (bus.RegWriteE && bus.RdE != 5'd0) begin
            regs[bus.RdE] <= bus.ResultE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= FLUSH_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        bubble     = 1'b0;
        case (state)
            FLUSH_IDLE: begin
                if (bus.FlushC) begin
                    bubble     = 1'b1;
                    state_next = FLUSH_PENDING;
                end
            end
            FLUSH_PENDING: begin
                bubble     = 1'b1;
                state_next = bus.FlushC ? FLUSH_PENDING : FLUSH_IDLE;
            end
            default: state_next = FLUSH_IDLE;
        endcase
    end

    // Datapath fields always advance; a bubble only clears the control bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.RD1C        <= '0;
            bus.RD2C        <= '0;
            bus.ImmExtC     <= '0;
            bus.PCC         <= '0;
            bus.PCPlus4C    <= '0;
            bus.Rs1C        <= '0;
            bus.Rs2C        <= '0;
            bus.RdC         <= '0;
            bus.Funct3C     <= '0;
            bus.RegWriteC   <= 1'b0;
            bus.MemWriteC   <= 1'b0;
            bus.JumpC       <= 1'b0;
            bus.BranchC     <= 1'b0;
            bus.ALUSrcC     <= 1'b0;
            bus.ALUSrcAC    <= 1'b0;
            bus.ResultSrcC  <= 2'b00;
            bus.ALUControlC <= 4'd0;
            bus.IllegalC    <= 1'b0;
        end else begin
            bus.RD1C        <= rd1;
            bus.RD2C        <= rd2;
            bus.ImmExtC     <= imm_ext;
            bus.PCC         <= bus.PCB;
            bus.PCPlus4C    <= bus.PCPlus4B;
            bus.Rs1C        <= rs1;
            bus.Rs2C        <= rs2;
            bus.RdC         <= rd;
            bus.Funct3C     <= funct3;
            bus.ALUSrcC     <= dec_alu_src;
            bus.ALUSrcAC    <= dec_alu_src_a;
            bus.ResultSrcC  <= dec_result_src;
            bus.ALUControlC <= dec_alu_ctrl;
            bus.RegWriteC   <= dec_reg_write & ~bubble;
            bus.MemWriteC   <= dec_mem_write & ~bubble;
            bus.JumpC       <= dec_jump & ~bubble;
            bus.BranchC     <= dec_branch & ~bubble;
            bus.IllegalC    <= dec_illegal & ~bubble;
        end
    end
endmodule
